// File: rtl/drac_pkg.sv
// Shared vector-datapath types plus the vector writeback arbiter's sizing constants
// and its per-source request record.
package drac_pkg;

  localparam int NUM_SIMD_WB = 2;
  localparam int PHVREG_W    = 6;
  localparam int SIMD_W      = 128;

  typedef logic [PHVREG_W-1:0] phvreg_t;
  typedef logic [SIMD_W-1:0]   bus_simd_t;

  localparam int VWB_NUM_SRC    = 4;
  localparam int VWB_FIFO_DEPTH = 2;

  typedef struct packed {
    phvreg_t   addr;
    bus_simd_t data;
  } vwb_req_t;

endpackage

// File: rtl/vwb_src_fifo.sv
// Single-source writeback FIFO: registered count drives full/empty, and a flush
// empties it and drops any same-cycle push.
module vwb_src_fifo
  import drac_pkg::*;
#(
  parameter int DEPTH = VWB_FIFO_DEPTH
) (
  input  logic     clk_i,
  input  logic     rstn_i,
  input  logic     flush_i,
  input  logic     push_i,
  input  vwb_req_t req_i,
  input  logic     pop_i,
  output vwb_req_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  vwb_req_t         mem_q [DEPTH];

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates visibility, so stale entries are never observed.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= req_i;
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rstn_i)
    count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/vwb_arbiter.sv
// Vector writeback front end: per-source FIFOs, round-robin grant of up to NUM_PORTS
// heads per cycle with same-address suppression, and registered register-file write ports.
module vwb_arbiter
  import drac_pkg::*;
#(
  parameter int NUM_SRC    = VWB_NUM_SRC,
  parameter int NUM_PORTS  = NUM_SIMD_WB,
  parameter int FIFO_DEPTH = VWB_FIFO_DEPTH
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 flush_i,
  input  logic [NUM_SRC-1:0]   src_valid_i,
  input  phvreg_t              src_addr_i [NUM_SRC],
  input  bus_simd_t            src_data_i [NUM_SRC],
  output logic [NUM_SRC-1:0]   src_ready_o,
  output logic [NUM_PORTS-1:0] write_enable_o,
  output phvreg_t              write_addr_o [NUM_PORTS],
  output bus_simd_t            write_data_o [NUM_PORTS],
  output logic                 busy_o
);

  localparam int RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]   empty, full, pop;
  vwb_req_t             head [NUM_SRC];
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [NUM_PORTS-1:0] gnt_vld;
  vwb_req_t             gnt_req [NUM_PORTS];
  logic                 conflict, placed;

  logic [NUM_PORTS-1:0] we_q, we_d;
  phvreg_t              waddr_q [NUM_PORTS];
  phvreg_t              waddr_d [NUM_PORTS];
  bus_simd_t            wdata_q [NUM_PORTS];
  bus_simd_t            wdata_d [NUM_PORTS];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo
    vwb_req_t req;
    assign req.addr = src_addr_i[s];
    assign req.data = src_data_i[s];

    vwb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .flush_i(flush_i),
      .push_i (src_valid_i[s]),
      .req_i  (req),
      .pop_i  (pop[s]),
      .head_o (head[s]),
      .full_o (full[s]),
      .empty_o(empty[s])
    );
  end

  assign src_ready_o = ~full;

  // Scan from rr_q; each head takes the lowest free port unless its address is already granted.
  always_comb begin
    gnt_vld  = '0;
    pop      = '0;
    rr_d     = rr_q;
    conflict = 1'b0;
    placed   = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) gnt_req[p] = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (s == (int'(rr_q) + i) % NUM_SRC && !empty[s]) begin
          conflict = 1'b0;
          placed   = 1'b0;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_vld[p] && gnt_req[p].addr == head[s].addr) conflict = 1'b1;
          end
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (!conflict && !placed && !gnt_vld[p]) begin
              gnt_vld[p] = 1'b1;
              gnt_req[p] = head[s];
              pop[s]     = 1'b1;
              rr_d       = RR_W'((s + 1) % NUM_SRC);
              placed     = 1'b1;
            end
          end
        end
      end
    end
    if (flush_i) rr_d = '0;
  end

  // Idle ports keep their last addr/data so the register file bus only toggles on real writes.
  always_comb begin
    we_d = flush_i ? '0 : gnt_vld;
    for (int p = 0; p < NUM_PORTS; p++) begin
      waddr_d[p] = waddr_q[p];
      wdata_d[p] = wdata_q[p];
      if (gnt_vld[p] && !flush_i) begin
        waddr_d[p] = gnt_req[p].addr;
        wdata_d[p] = gnt_req[p].data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_q <= '0;
      we_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        waddr_q[p] <= '0;
        wdata_q[p] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      we_q <= we_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        waddr_q[p] <= waddr_d[p];
        wdata_q[p] <= wdata_d[p];
      end
    end
  end

  assign write_enable_o = we_q;
  assign write_addr_o   = waddr_q;
  assign write_data_o   = wdata_q;
  assign busy_o         = (~&empty) | (|we_q);

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_hold_chk
    a_valid_hold: assert property (@(posedge clk_i) disable iff (!rstn_i)
      (src_valid_i[s] && !src_ready_o[s]) |=> src_valid_i[s]);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dup_chk_a
    for (genvar q = p + 1; q < NUM_PORTS; q++) begin : g_dup_chk_b
      a_no_dup_addr: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(we_q[p] && we_q[q] && waddr_q[p] == waddr_q[q]));
    end
  end

endmodule

// File: doc/vwb_arbiter.md
Name: vwb_arbiter

Overview:
- Producer-side front end of the vector register file write ports.
- Collects writeback results from NUM_SRC vector producers (SIMD ALU, vector load path, reduction unit, ...) through valid/ready handshakes and buffers each in a small per-source FIFO.
- Each cycle, grants up to NUM_SIMD_WB FIFO heads in round-robin order and drives registered write_enable/addr/data bundles into the register file.
- Never issues two same-cycle writes to one physical vector register.

Parameters:
- NUM_SRC, 4, number of producer sources.
- NUM_PORTS, NUM_SIMD_WB, register file write ports driven. Must satisfy 1 <= NUM_PORTS <= NUM_SRC.
- FIFO_DEPTH, 2, entries per source FIFO. Power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all buffered and in-flight writes.
- src_valid_i  in  NUM_SRC  producer has a result.
- src_addr_i  in  NUM_SRC x phvreg_t  destination physical vreg.
- src_data_i  in  NUM_SRC x bus_simd_t  result data.
- src_ready_o  out  NUM_SRC  FIFO of that source not full.
- write_enable_o  out  NUM_PORTS  port write strobe to the register file.
- write_addr_o  out  NUM_PORTS x phvreg_t  port destination.
- write_data_o  out  NUM_PORTS x bus_simd_t  port data.
- busy_o  out  1  any FIFO non-empty or any write_enable_o set.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - FIFOs empty; rr pointer = 0.
  - write_enable_o = 0, write_addr_o = 0, write_data_o = 0.
  - src_ready_o = all 1; busy_o = 0.
- Enqueue:
  - Source s enqueues at the clock edge when src_valid_i[s] && src_ready_o[s].
  - src_ready_o[s] = (count[s] != FIFO_DEPTH), taken from registered count only. No combinational path from any input.
  - A full FIFO deasserts ready even if it is dequeued in the same cycle.
- Arbitration (combinational, every cycle, over non-empty FIFO heads):
  - Scan sources starting at rr pointer, wrapping modulo NUM_SRC.
  - Assign grants to ports 0, 1, ... in scan order until NUM_PORTS grants are made or the scan ends.
  - A head whose address equals the address of an already-granted head this cycle is skipped, stays queued and is retried next cycle.
  - Granted heads pop at the clock edge.
- Rr pointer update:
  - If at least one grant was made: rr pointer = (last granted source + 1) mod NUM_SRC.
  - If no grant was made: rr pointer unchanged.
- Output register:
  - write_*_o are registered from the grants. Unused ports have enable = 0; their addr/data hold their previous value.
  - Latency: handshake in cycle N -> earliest write_enable_o in cycle N+2. FIFO head is visible in N+1, output is registered at the end of N+1.
  - Throughput: NUM_PORTS writes per cycle sustained. A single source sustains 1 write per cycle with FIFO_DEPTH >= 2.
- Ordering:
  - Writes from one source leave in enqueue order.
  - No ordering is guaranteed across sources.
- Flush (flush_i high at an edge):
  - All FIFOs emptied; write_enable_o cleared next cycle.
  - An enqueue in the same cycle is dropped.
  - rr pointer reset to 0.
  - flush_i has priority over every other event.
- Simultaneous enqueue and dequeue on a non-full FIFO: count unchanged, pointers both advance.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is $clog2(FIFO_DEPTH+1) bits.
- Assertions:
  - count never exceeds FIFO_DEPTH.
  - No two enabled output ports carry equal write_addr_o.
  - src_valid_i is held until accepted (producer rule; checked, not relied on).

Decomposition:
- Shared drac_pkg:
  - Reuse phvreg_t, bus_simd_t, NUM_SIMD_WB.
  - Add VWB_NUM_SRC and VWB_FIFO_DEPTH constants.
  - Add typedef vwb_req_t {phvreg_t addr; bus_simd_t data;}.
- Sub-module: vwb_src_fifo, a parameterised single-source FIFO with count, full/empty, flush. Instantiated NUM_SRC times.
- Arbiter and output register stay in vwb_arbiter.

Test Plan:
- Single write:
  - Stimulus: src 0 writes addr 5, data 0xA5 in cycle 1.
  - Response: write_enable_o = 01, addr 5, data 0xA5 in cycle 3. busy_o deasserts in cycle 4.
- All sources contend (NUM_PORTS = 2, rr = 0):
  - Stimulus: srcs 0..3 valid with addrs 1, 2, 3, 4.
  - Response: grants {0, 1} then {2, 3}. rr ends at 0. Four writes over two consecutive cycles.
- Same-address conflict:
  - Stimulus: srcs 0 and 1 both target addr 7 (data 0x11, 0x22).
  - Response: port 0 writes 0x11; src 1's write is deferred one cycle. No cycle has two enables with addr 7.
- Backpressure:
  - Stimulus: src 2 streams 5 results while srcs 0 and 1 saturate both ports.
  - Response: src_ready_o[2] = 0 once 2 entries are queued. No loss; src 2 data emerges in order once granted.
- Flush:
  - Stimulus: 3 FIFOs hold entries; flush_i pulses while src 0 is enqueuing.
  - Response: write_enable_o = 0 from the next cycle. All ready_o = 1. The dropped entry never appears.
- Async reset mid-stream:
  - Stimulus: rstn_i low between clock edges.
  - Response: write_enable_o = 0 immediately. After release, the first new write appears 2 cycles after its handshake.
